// File: rtl/score_display_scan_if.sv
// score_display_scan_if: score/game-state inputs and seven-segment drive outputs.
interface score_display_scan_if;
    logic [7:0] binaryruns;
    logic [3:0] binarywickets;
    logic       inningOver;
    logic       gameOver;
    logic       winner;
    logic [3:0] an;
    logic [6:0] ca;
    logic       dp;
    modport master (output binaryruns, binarywickets, inningOver, gameOver, winner, input an, ca, dp);
    modport slave  (input binaryruns, binarywickets, inningOver, gameOver, winner, output an, ca, dp);
endinterface

// File: rtl/score_display_scan.sv
// score_display_scan: runs/wickets to multiplexed 4-digit seven-segment drive
// with sequential binary-to-BCD, inning-over blink and winner message.
module score_display_scan #(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 50_000_000
) (
    input logic clk_fpga,
    input logic reset,
    score_display_scan_if.slave bus
);
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_t;
    conv_t       st;
    logic [7:0]  last_runs, sh;
    logic [11:0] scr, adj;
    logic [2:0]  bit_cnt;
    logic [3:0]  dig_h, dig_t, dig_u;
    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]  idx;
    logic        ref_tc, blink_run, blink_tc, blink_off, blink_off_n, dp_n;
    logic [6:0]  ca_n;
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'h40;
            4'd1: glyph = 7'h79;
            4'd2: glyph = 7'h24;
            4'd3: glyph = 7'h30;
            4'd4: glyph = 7'h19;
            4'd5: glyph = 7'h12;
            4'd6: glyph = 7'h02;
            4'd7: glyph = 7'h78;
            4'd8: glyph = 7'h00;
            4'd9: glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
    endfunction
    always_comb begin
        adj[3:0]  = scr[3:0]  >= 4'd5 ? scr[3:0]  + 4'd3 : scr[3:0];
        adj[7:4]  = scr[7:4]  >= 4'd5 ? scr[7:4]  + 4'd3 : scr[7:4];
        adj[11:8] = scr[11:8] >= 4'd5 ? scr[11:8] + 4'd3 : scr[11:8];
    end
    // Display digits only change in LOAD, so the scan never sees a partial result.
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            last_runs <= '0;
            sh        <= '0;
            scr       <= '0;
            bit_cnt   <= '0;
            dig_h     <= '0;
            dig_t     <= '0;
            dig_u     <= '0;
        end else begin
            case (st)
                IDLE: if (bus.binaryruns != last_runs) begin
                    sh        <= bus.binaryruns;
                    last_runs <= bus.binaryruns;
                    scr       <= '0;
                    bit_cnt   <= '0;
                    st        <= SHIFT;
                end
                SHIFT: begin
                    {scr, sh} <= {adj, sh} << 1;
                    bit_cnt   <= bit_cnt + 3'd1;
                    st        <= bit_cnt == 3'd7 ? LOAD : SHIFT;
                end
                LOAD: begin
                    dig_h <= scr[11:8];
                    dig_t <= scr[7:4];
                    dig_u <= scr[3:0];
                    st    <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
    assign ref_tc      = ref_cnt == RW'(REFRESH_DIV - 1);
    assign blink_run   = bus.inningOver & ~bus.gameOver;
    assign blink_tc    = blink_cnt == BW'(BLINK_DIV - 1);
    assign blink_off_n = blink_run & (blink_tc ? ~blink_off : blink_off);
    always_comb begin
        ca_n = 7'h7F;
        dp_n = 1'b1;
        if (bus.gameOver)
            case (idx)
                2'd2: ca_n = 7'h07;
                2'd1: ca_n = 7'h3F;
                2'd0: ca_n = bus.winner ? 7'h24 : 7'h79;
                default: ca_n = 7'h7F;
            endcase
        else
            case (idx)
                2'd3: begin
                    ca_n = bus.binarywickets >= 4'd10 ? 7'h08 : glyph(bus.binarywickets);
                    dp_n = 1'b0;
                end
                2'd2: ca_n = dig_h == 4'd0 ? 7'h7F : glyph(dig_h);
                2'd1: ca_n = (dig_h == 4'd0 && dig_t == 4'd0) ? 7'h7F : glyph(dig_t);
                default: ca_n = glyph(dig_u);
            endcase
    end
    // Anode, cathode and dp share one register stage so they switch on the same edge.
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            ref_cnt   <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
            bus.an    <= 4'b1111;
            bus.ca    <= 7'h7F;
            bus.dp    <= 1'b1;
        end else begin
            ref_cnt   <= ref_tc ? '0 : ref_cnt + RW'(1);
            idx       <= ref_tc ? idx + 2'd1 : idx;
            blink_cnt <= (!blink_run || blink_tc) ? '0 : blink_cnt + BW'(1);
            blink_off <= blink_off_n;
            bus.an    <= blink_off_n ? 4'b1111 : ~(4'b0001 << idx);
            bus.ca    <= ca_n;
            bus.dp    <= dp_n;
        end
    end
endmodule
